// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester indices.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    assign gnt_valid_o = req0_i | req1_i;
    assign gnt_idx_o   = (req0_i && req1_i) ? ~last_grant_i : (req1_i ? PORT_M1 : PORT_M0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one word-indexed data memory between the CPU MEM stage (m0) and a loader/debug port (m1)
// with round-robin grant, fixed wait states and a single registered write strobe per transaction.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_grant_q;
    logic              port_q;
    logic              we_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    logic              gnt_valid, gnt_idx;
    logic              sel_we_d, sel_in_range_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    rr_arbiter2 u_rr (
        .req0_i       (m0_req_i),
        .req1_i       (m1_req_i),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx)
    );

    always_comb begin
        sel_we_d       = (gnt_idx == PORT_M1) ? m1_we_i    : m0_we_i;
        sel_addr_d     = (gnt_idx == PORT_M1) ? m1_addr_i  : m0_addr_i;
        sel_wdata_d    = (gnt_idx == PORT_M1) ? m1_wdata_i : m0_wdata_i;
        sel_in_range_d = (sel_addr_d < ADDR_W'(DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_M1;
            port_q       <= PORT_M0;
            we_q         <= 1'b0;
            in_range_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            // Completion outputs are single-cycle: cleared unless set below.
            mem_we_q   <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        port_q       <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        we_q         <= sel_we_d;
                        in_range_q   <= sel_in_range_d;
                        mem_addr_q   <= sel_addr_d;
                        mem_wdata_q  <= sel_wdata_d;
                        cnt_q        <= '0;
                        state_q      <= ACCESS;
                        if (WAIT_CYCLES == 1) mem_we_q <= sel_we_d && sel_in_range_d;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        if (port_q == PORT_M1) begin
                            m1_ack_q   <= 1'b1;
                            m1_err_q   <= ~in_range_q;
                            m1_rdata_q <= (!we_q && in_range_q) ? mem_rdata_i : '0;
                        end else begin
                            m0_ack_q   <= 1'b1;
                            m0_err_q   <= ~in_range_q;
                            m0_rdata_q <= (!we_q && in_range_q) ? mem_rdata_i : '0;
                        end
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        // Strobe is registered, so raise it on entry to the final cycle.
                        mem_we_q <= we_q && in_range_q && (cnt_q == CNT_LAST - 1'b1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_ack_o    = m0_ack_q;
    assign m1_ack_o    = m1_ack_q;
    assign m0_err_o    = m0_err_q;
    assign m1_err_o    = m1_err_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = (state_q != IDLE);

endmodule
